// File: rtl/branch_pred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and mispredict pulses.
// Optional branch/mispredict statistics counters are enabled by defining BP_STATS_EN.
module branch_pred_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_fetch_pc,
  input  logic        i_fetch_valid,
  input  logic        i_fetch_hold,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_pc,
  output logic        o_pred_jump,
  output logic [31:0] o_pred_pc,
  output logic        o_nt_pt,
  output logic        o_t_pnt
`ifdef BP_STATS_EN
  ,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
`endif
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic               valid_r  [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];

  logic [IDX_W-1:0]   fetch_idx_s, ex_idx_s;
  logic [TAG_W-1:0]   fetch_tag_s, ex_tag_s;
  logic               fetch_hit_s, ex_hit_s;
  logic               res_s, nt_pt_s, t_pnt_s, mispred_s, pred_allow_s;
  logic               unused_bits_s;

  assign fetch_idx_s   = i_fetch_pc[IDX_W+1:2];
  assign fetch_tag_s   = i_fetch_pc[31:IDX_W+2];
  assign ex_idx_s      = i_ex_pc[IDX_W+1:2];
  assign ex_tag_s      = i_ex_pc[31:IDX_W+2];
  assign unused_bits_s = ^{i_fetch_pc[1:0], i_ex_pc[1:0]};

  // Fetch-side lookup; sees table contents from before any same-cycle update.
  always_comb begin
    fetch_hit_s = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
    if (fetch_hit_s) begin
      o_pred_pc = target_r[fetch_idx_s];
    end else begin
      o_pred_pc = 32'h0000_0000;
    end
    o_pred_jump = fetch_hit_s & ctr_r[fetch_idx_s][1] & i_fetch_valid & ~i_fetch_hold
                & pred_allow_s & ~o_nt_pt & ~o_t_pnt;
  end

  // Resolution classification from EX.
  always_comb begin
    res_s     = i_ex_valid & i_ex_is_branch;
    ex_hit_s  = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
    nt_pt_s   = res_s & i_ex_pred_taken & ~i_ex_taken;
    t_pnt_s   = res_s & i_ex_taken & (~i_ex_pred_taken | (i_ex_pred_pc != i_ex_target));
    mispred_s = nt_pt_s | t_pnt_s;
  end

  // Recovery FSM next state; prediction is blocked for the cycle after a mispredict.
  always_comb begin
    state_s      = state_r;
    pred_allow_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        pred_allow_s = 1'b1;
        if (mispred_s) begin
          state_s = ST_RECOVER;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RECOVER: begin
        pred_allow_s = 1'b0;
        if (mispred_s) begin
          state_s = ST_RECOVER;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s      = ST_RUN;
        pred_allow_s = 1'b0;
      end
    endcase
  end

  // FSM state and mispredict pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      o_nt_pt <= 1'b0;
      o_t_pnt <= 1'b0;
    end else begin
      state_r <= state_s;
      o_nt_pt <= nt_pt_s;
      o_t_pnt <= t_pnt_s;
    end
  end

  // Table update: train on hit, allocate only on taken miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'h0000_0000;
        ctr_r[i]    <= 2'b01;
      end
    end else if (res_s) begin
      if (ex_hit_s) begin
        if (i_ex_taken) begin
          target_r[ex_idx_s] <= i_ex_target;
          if (ctr_r[ex_idx_s] != 2'b11) begin
            ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] + 2'b01;
          end
        end else if (ctr_r[ex_idx_s] != 2'b00) begin
          ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] - 2'b01;
        end
      end else if (i_ex_taken) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= i_ex_target;
        ctr_r[ex_idx_s]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating branch and mispredict statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_br_cnt      <= 32'h0000_0000;
      o_mispred_cnt <= 32'h0000_0000;
    end else begin
      if (res_s && (o_br_cnt != 32'hFFFF_FFFF)) begin
        o_br_cnt <= o_br_cnt + 32'h0000_0001;
      end
      if (mispred_s && (o_mispred_cnt != 32'hFFFF_FFFF)) begin
        o_mispred_cnt <= o_mispred_cnt + 32'h0000_0001;
      end
    end
  end
`endif

endmodule

// File: doc/branch_pred_btb.md
Name: branch_pred_btb

Overview:
Direct-mapped branch target buffer with 2-bit saturating counters. It sits beside the fetch PC register and is the producing end of its prediction interface. It looks up the current fetch PC each cycle and drives predicted-taken/target back to the PC register. It takes branch resolutions from EX, updates the table, and reports both mispredict classes as registered one-cycle pulses.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 4..256
IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_fetch_pc  in  32  current fetch PC (PC register output)
i_fetch_valid  in  1  fetch PC is meaningful this cycle
i_fetch_hold  in  1  OR of stall/wait conditions; PC will not advance
i_ex_valid  in  1  EX stage holds a valid instruction
i_ex_is_branch  in  1  EX instruction is a conditional branch or jal
i_ex_pc  in  32  PC of EX instruction
i_ex_taken  in  1  resolved direction
i_ex_target  in  32  resolved target
i_ex_pred_taken  in  1  prediction carried down the pipe with this instruction
i_ex_pred_pc  in  32  predicted target carried down the pipe
o_pred_jump  out  1  redirect fetch to o_pred_pc (combinational)
o_pred_pc  out  32  predicted target (combinational)
o_nt_pt  out  1  registered pulse: predicted taken, resolved not taken
o_t_pnt  out  1  registered pulse: predicted not taken or wrong target, resolved taken

Behaviour:
- Storage per entry: valid, tag[31-IDX_W-2:0], target[31:0], ctr[1:0]. Reset: valid=0, ctr=2'b01, tag/target=0.
- Lookup (combinational): hit = valid[idx] & tag match. o_pred_pc = target[idx], or 0 on miss.
- o_pred_jump = hit & ctr[1] & i_fetch_valid & !i_fetch_hold & (state==RUN) & !o_nt_pt & !o_t_pnt.
- Resolution event R = i_ex_valid & i_ex_is_branch. On R at the clock edge:
  - Hit at ex index: ctr saturating +1 if taken (max 3), -1 if not (min 0). If taken, target <= i_ex_target.
  - Miss and taken: allocate/replace. valid=1, tag, target=i_ex_target, ctr=2'b10.
  - Miss and not taken: no write.
- Mispredict flags, registered; both reset 0:
  - o_nt_pt <= R & i_ex_pred_taken & !i_ex_taken.
  - o_t_pnt <= R & i_ex_taken & (!i_ex_pred_taken | i_ex_pred_pc != i_ex_target).
  - Each is a single-cycle pulse; never both high in the same cycle.
- FSM, 2 states, reset RUN:
  - RUN -> RECOVER when either mispredict flag is being set.
  - RECOVER -> RUN after exactly one cycle; a new mispredict in RECOVER re-enters RECOVER.
  - Predictions are suppressed in RECOVER, so the redirected PC issues before any new prediction.
- Lookup and update at the same index in the same cycle: the lookup sees pre-update contents (write at edge, no bypass).
- i_fetch_hold high: table updates still occur; o_pred_jump is held 0.
- Reset mid-operation: all entries, flags and FSM return to reset values asynchronously. o_pred_jump=0 while rst is high.
- Address bits [1:0] are ignored for index and tag.

Optional Feature:
BP_STATS_EN:
- Defined: adds outputs o_br_cnt[31:0] and o_mispred_cnt[31:0], both reset 0.
  - o_br_cnt increments on each R.
  - o_mispred_cnt increments on each cycle where o_nt_pt or o_t_pnt is being set.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, i_fetch_pc=32'h100 with valid=1 -> o_pred_jump=0, o_pred_pc=0.
- R at pc 32'h100, taken, target 32'h200, pred_taken=0 -> next cycle o_t_pnt=1 for one cycle, then one RECOVER cycle. Afterwards fetch 32'h100 -> o_pred_jump=1, o_pred_pc=32'h200.
- Same branch resolved not taken twice with pred_taken=1 -> o_nt_pt pulses each time; ctr goes 2->1->0; fetch 32'h100 -> o_pred_jump=0 on hit.
- Alias test: entry at 32'h100 allocated, then fetch 32'h140 (same index, different tag) -> miss, o_pred_jump=0. A taken R at 32'h140 replaces the entry; 32'h100 then misses.
- Predicted taken to 32'h200, resolved taken to 32'h300 -> o_t_pnt=1; entry target becomes 32'h300.
- Hit with ctr=3, i_fetch_hold=1 -> o_pred_jump=0. Release hold -> 1. Assert rst mid-run -> table invalid, no prediction. With BP_STATS_EN, counters return to 0.
